// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// phases, instruction classes, opcodes/functs and ALU selects.
package uc_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_EXEC   = 3'b011,
    ST_MEM    = 3'b100,
    ST_WB     = 3'b110
  } state_t;

  localparam logic [7:0] CL_ILL = 8'h00;
  localparam logic [7:0] CL_R   = 8'h01;
  localparam logic [7:0] CL_I   = 8'h02;
  localparam logic [7:0] CL_LW  = 8'h03;
  localparam logic [7:0] CL_SW  = 8'h04;
  localparam logic [7:0] CL_BR  = 8'h05;
  localparam logic [7:0] CL_JAL = 8'h06;
  localparam logic [7:0] CL_J   = 8'h07;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  function automatic logic [3:0] alu_funct(
    input logic [5:0] fn
  );
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/uc_decodificador.sv
// Combinational IR classifier: class, ALU select,
// register indices and extended immediate.
module uc_decodificador
  import uc_pkg::*;
(
  input  logic [31:0] ir,
  output logic [7:0]  cls,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       r_ok;

  assign op   = ir[31:26];
  assign fn   = ir[5:0];
  assign rs   = ir[25:21];
  assign rt   = ir[20:16];
  assign r_ok = (op == OP_R) &&
    (fn inside {FN_ADD, FN_SUB, FN_AND,
                FN_OR, FN_SLT});

  always_comb begin
    cls     = CL_ILL;
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    rd      = '0;
    imm     = {{16{ir[15]}}, ir[15:0]};
    unique case (1'b1)
      r_ok: begin
        cls    = CL_R;
        rd     = ir[15:11];
        alu_op = alu_funct(fn);
      end
      op == OP_ADDI: begin
        cls     = CL_I;
        rd      = ir[20:16];
        alu_src = 1'b1;
      end
      op == OP_SLTI: begin
        cls     = CL_I;
        rd      = ir[20:16];
        alu_src = 1'b1;
        alu_op  = ALU_SLT;
      end
      // logical immediates are zero-extended
      op == OP_ANDI: begin
        cls     = CL_I;
        rd      = ir[20:16];
        alu_src = 1'b1;
        alu_op  = ALU_AND;
        imm     = {16'h0000, ir[15:0]};
      end
      op == OP_ORI: begin
        cls     = CL_I;
        rd      = ir[20:16];
        alu_src = 1'b1;
        alu_op  = ALU_OR;
        imm     = {16'h0000, ir[15:0]};
      end
      op == OP_LW: begin
        cls     = CL_LW;
        rd      = ir[20:16];
        alu_src = 1'b1;
      end
      op == OP_SW: begin
        cls     = CL_SW;
        alu_src = 1'b1;
      end
      op == OP_BEQ, op == OP_BNE: begin
        cls    = CL_BR;
        alu_op = ALU_SUB;
      end
      op == OP_JAL: begin
        cls = CL_JAL;
        rd  = 5'd31;
      end
      op == OP_J: cls = CL_J;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle MIPS control unit: fetch handshake, IR,
// phase sequencing and memory timeout.
module unidade_de_controle
  import uc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        uc_in_clk,
  input  logic        uc_in_rst_n,
  input  logic [31:0] uc_in_instr,
  input  logic        uc_in_instr_valid,
  input  logic        uc_in_zero,
  input  logic        uc_in_mem_ack,
  output logic [2:0]  uc_out_FSM,
  output logic [7:0]  uc_out_FSM2,
  output logic [4:0]  uc_out_rs,
  output logic [4:0]  uc_out_rt,
  output logic [4:0]  uc_out_rd,
  output logic [31:0] uc_out_imm,
  output logic [3:0]  uc_out_alu_op,
  output logic        uc_out_alu_src,
  output logic        uc_out_fetch_req,
  output logic        uc_out_mem_req,
  output logic        uc_out_mem_we,
  output logic        uc_out_pc_write,
  output logic [1:0]  uc_out_pc_sel,
  output logic        uc_out_err
);

  localparam int CW = $clog2(MEM_TIMEOUT) + 1;

  state_t         state;
  state_t         nxt;
  logic [31:0]    ir;
  logic [CW-1:0]  cnt;
  logic [7:0]     cls;
  logic [3:0]     aop;
  logic           asrc;
  logic [4:0]     rs;
  logic [4:0]     rt;
  logic [4:0]     rd;
  logic [31:0]    imm;
  logic           show;
  logic           take;
  logic           last;

  uc_decodificador u_dec (
    .ir      (ir),
    .cls     (cls),
    .alu_op  (aop),
    .alu_src (asrc),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .imm     (imm)
  );

  assign take = (ir[31:26] == OP_BNE) ?
    !uc_in_zero : uc_in_zero;
  assign last = (cnt == CW'(MEM_TIMEOUT - 1));
  assign show = state inside
    {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};

  always_ff @(posedge uc_in_clk or negedge uc_in_rst_n) begin
    if (!uc_in_rst_n) begin
      state <= ST_RESET;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (state == ST_FETCH && uc_in_instr_valid)
        ir <= uc_in_instr;
      // zero outside MEM, so every MEM visit starts at 0
      cnt <= (state == ST_MEM) ? cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    nxt              = state;
    uc_out_FSM       = state;
    uc_out_FSM2      = show ? cls : '0;
    uc_out_rs        = show ? rs  : '0;
    uc_out_rt        = show ? rt  : '0;
    uc_out_rd        = show ? rd  : '0;
    uc_out_imm       = show ? imm : '0;
    uc_out_alu_op    = '0;
    uc_out_alu_src   = 1'b0;
    uc_out_fetch_req = 1'b0;
    uc_out_mem_req   = 1'b0;
    uc_out_mem_we    = 1'b0;
    uc_out_pc_write  = 1'b0;
    uc_out_pc_sel    = PC_SEQ;
    uc_out_err       = 1'b0;
    unique case (state)
      ST_RESET: nxt = ST_FETCH;
      ST_FETCH: begin
        uc_out_fetch_req = 1'b1;
        if (uc_in_instr_valid) nxt = ST_DECODE;
      end
      ST_DECODE: nxt = ST_EXEC;
      ST_EXEC: begin
        uc_out_alu_op  = aop;
        uc_out_alu_src = asrc;
        unique case (cls)
          CL_R, CL_I, CL_JAL: nxt = ST_WB;
          CL_LW, CL_SW:       nxt = ST_MEM;
          CL_BR: begin
            uc_out_pc_write = 1'b1;
            uc_out_pc_sel   = take ? PC_BR : PC_SEQ;
            nxt             = ST_FETCH;
          end
          CL_J: begin
            uc_out_pc_write = 1'b1;
            uc_out_pc_sel   = PC_JMP;
            nxt             = ST_FETCH;
          end
          default: begin
            uc_out_err      = 1'b1;
            uc_out_pc_write = 1'b1;
            nxt             = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        uc_out_mem_req = 1'b1;
        uc_out_mem_we  = (cls == CL_SW);
        if (uc_in_mem_ack) begin
          if (cls == CL_LW) begin
            nxt = ST_WB;
          end else begin
            uc_out_pc_write = 1'b1;
            nxt             = ST_FETCH;
          end
        end else if (last) begin
          uc_out_err      = 1'b1;
          uc_out_pc_write = 1'b1;
          nxt             = ST_FETCH;
        end
      end
      ST_WB: begin
        uc_out_pc_write = 1'b1;
        uc_out_pc_sel   = (cls == CL_JAL) ? PC_JMP : PC_SEQ;
        nxt             = ST_FETCH;
      end
      default: nxt = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_unidade_de_controle.sv
// Scoreboard bench for unidade_de_controle: directed and
// random instructions against a per-instruction outcome model.
module tb_unidade_de_controle;
  import uc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        zero = 1'b0;
  logic        ack = 1'b0;

  logic [2:0]  uc_out_FSM;
  logic [7:0]  uc_out_FSM2;
  logic [4:0]  uc_out_rs;
  logic [4:0]  uc_out_rt;
  logic [4:0]  uc_out_rd;
  logic [31:0] uc_out_imm;
  logic [3:0]  uc_out_alu_op;
  logic        uc_out_alu_src;
  logic        uc_out_fetch_req;
  logic        uc_out_mem_req;
  logic        uc_out_mem_we;
  logic        uc_out_pc_write;
  logic [1:0]  uc_out_pc_sel;
  logic        uc_out_err;

  unidade_de_controle #(.MEM_TIMEOUT(16)) dut (
    .uc_in_clk         (clk),
    .uc_in_rst_n       (rst_n),
    .uc_in_instr       (instr),
    .uc_in_instr_valid (valid),
    .uc_in_zero        (zero),
    .uc_in_mem_ack     (ack),
    .uc_out_FSM        (uc_out_FSM),
    .uc_out_FSM2       (uc_out_FSM2),
    .uc_out_rs         (uc_out_rs),
    .uc_out_rt         (uc_out_rt),
    .uc_out_rd         (uc_out_rd),
    .uc_out_imm        (uc_out_imm),
    .uc_out_alu_op     (uc_out_alu_op),
    .uc_out_alu_src    (uc_out_alu_src),
    .uc_out_fetch_req  (uc_out_fetch_req),
    .uc_out_mem_req    (uc_out_mem_req),
    .uc_out_mem_we     (uc_out_mem_we),
    .uc_out_pc_write   (uc_out_pc_write),
    .uc_out_pc_sel     (uc_out_pc_sel),
    .uc_out_err        (uc_out_err)
  );

  always #5 clk = ~clk;

  logic others;
  assign others = |{uc_out_FSM2, uc_out_rs, uc_out_rt,
    uc_out_rd, uc_out_imm, uc_out_alu_op, uc_out_alu_src,
    uc_out_mem_req, uc_out_mem_we, uc_out_pc_write,
    uc_out_pc_sel, uc_out_err};

  typedef struct {
    int          cls;
    int          rs;
    int          rt;
    int          rd;
    bit          ck_rd;
    logic [31:0] imm;
    int          aop;
    int          asrc;
    bit          ck_alu;
    int          n_mem;
    int          n_we;
    int          n_wb;
    int          pcsel;
    int          pcph;
    int          err;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   sb_on = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Outcome of one instruction from the architectural rules
  function automatic exp_t model(input logic [31:0] w,
                                 input logic z,
                                 input int d);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    bit acked;
    op = w[31:26];
    fn = w[5:0];
    e.cls = 0; e.rs = int'(w[25:21]); e.rt = int'(w[20:16]);
    e.rd = 0; e.ck_rd = 0; e.ck_alu = 0; e.aop = 0; e.asrc = 0;
    e.imm = {{16{w[15]}}, w[15:0]};
    case (op)
      6'h00: begin
        e.asrc = 0; e.rd = int'(w[15:11]);
        case (fn)
          6'h20: begin e.cls = 1; e.aop = ALU_ADD; end
          6'h22: begin e.cls = 1; e.aop = ALU_SUB; end
          6'h24: begin e.cls = 1; e.aop = ALU_AND; end
          6'h25: begin e.cls = 1; e.aop = ALU_OR;  end
          6'h2A: begin e.cls = 1; e.aop = ALU_SLT; end
          default: e.cls = 0;
        endcase
      end
      6'h08: begin e.cls = 2; e.aop = ALU_ADD; e.asrc = 1; end
      6'h0A: begin e.cls = 2; e.aop = ALU_SLT; e.asrc = 1; end
      6'h0C: begin
        e.cls = 2; e.aop = ALU_AND; e.asrc = 1;
        e.imm = {16'h0, w[15:0]};
      end
      6'h0D: begin
        e.cls = 2; e.aop = ALU_OR; e.asrc = 1;
        e.imm = {16'h0, w[15:0]};
      end
      6'h23: begin e.cls = 3; e.aop = ALU_ADD; e.asrc = 1; end
      6'h2B: begin e.cls = 4; e.aop = ALU_ADD; e.asrc = 1; end
      6'h04, 6'h05: begin e.cls = 5; e.aop = ALU_SUB; end
      6'h03: e.cls = 6;
      6'h02: e.cls = 7;
      default: e.cls = 0;
    endcase
    if (e.cls == 2 || e.cls == 3) e.rd = int'(w[20:16]);
    if (e.cls == 6) e.rd = 31;
    e.ck_rd  = e.cls inside {1, 2, 3, 6};
    e.ck_alu = e.cls inside {1, 2, 3, 4, 5};
    acked  = d < 16;
    e.n_mem = 0; e.n_wb = 0; e.err = 0; e.pcsel = 0; e.pcph = 3;
    case (e.cls)
      1, 2: begin e.n_wb = 1; e.pcph = 6; end
      6: begin e.n_wb = 1; e.pcph = 6; e.pcsel = 2; end
      5: begin
        if ((op == 6'h04) ? z : !z) e.pcsel = 1;
      end
      7: e.pcsel = 2;
      0: e.err = 1;
      default: begin
        e.n_mem = acked ? d + 1 : 16;
        e.err   = acked ? 0 : 1;
        e.pcph  = 4;
        if (e.cls == 3 && acked) begin
          e.n_wb = 1; e.pcph = 6;
        end
      end
    endcase
    e.n_we = (e.cls == 4) ? e.n_mem : 0;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: begin
        w[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: w[5:0] = 6'h20;
          1: w[5:0] = 6'h22;
          2: w[5:0] = 6'h24;
          3: w[5:0] = 6'h25;
          4: w[5:0] = 6'h2A;
          default: ;
        endcase
      end
      1: w[31:26] = 6'h08;
      2: w[31:26] = 6'h0A;
      3: w[31:26] = 6'h0C;
      4: w[31:26] = 6'h0D;
      5: w[31:26] = 6'h23;
      6: w[31:26] = 6'h2B;
      7: w[31:26] = 6'h04;
      8: w[31:26] = 6'h05;
      9: w[31:26] = 6'h03;
      10: w[31:26] = 6'h02;
      default: ;
    endcase
    return w;
  endfunction

  function automatic int rand_delay();
    case ($urandom_range(0, 9))
      7: return 15;
      8: return 16;
      9: return int'($urandom_range(17, 19));
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic issue(input logic [31:0] w,
                       input logic z,
                       input int d);
    int t;
    int m;
    bit inmem;
    t = 0;
    while (uc_out_FSM !== 3'b001 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("fetch_wait", {29'b0, uc_out_FSM}, 32'd1);
    if (sb_on) q.push_back(model(w, z, d));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    instr = w;
    valid = 1'b1;
    zero  = z;
    @(negedge clk);
    valid = 1'b0;
    instr = $urandom;
    m = 0;
    t = 0;
    while (uc_out_FSM !== 3'b001 && t < 100) begin
      inmem = (uc_out_FSM == 3'b100);
      ack   = inmem && (m == d);
      @(negedge clk);
      if (inmem) m++;
      t++;
    end
    ack = 1'b0;
    chk("instr_end", {29'b0, uc_out_FSM}, 32'd1);
  endtask

  // Monitor: gathers one instruction's observed behaviour
  bit          act = 1'b0;
  logic [7:0]  o_cls;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [31:0] o_imm;
  logic [3:0]  o_aop;
  logic        o_asrc;
  logic [1:0]  o_sel;
  logic [2:0]  o_ph;
  bit          stable;
  int n_dec, n_ex, n_mem, n_wb, n_we, n_req, n_pcw, n_err;

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && sb_on) begin
      if (!act && uc_out_FSM == 3'b010) begin
        act = 1'b1;
        o_cls = uc_out_FSM2; o_rs = uc_out_rs; o_rt = uc_out_rt;
        o_rd = uc_out_rd; o_imm = uc_out_imm;
        o_aop = '0; o_asrc = 1'b0; o_sel = '0; o_ph = '0;
        stable = 1'b1;
        n_dec = 0; n_ex = 0; n_mem = 0; n_wb = 0;
        n_we = 0; n_req = 0; n_pcw = 0; n_err = 0;
      end
      if (act && uc_out_FSM != 3'b001) begin
        if ({uc_out_FSM2, uc_out_rs, uc_out_rt, uc_out_rd,
             uc_out_imm} !== {o_cls, o_rs, o_rt, o_rd, o_imm})
          stable = 1'b0;
        case (uc_out_FSM)
          3'b010: n_dec++;
          3'b011: begin
            n_ex++; o_aop = uc_out_alu_op; o_asrc = uc_out_alu_src;
          end
          3'b100: n_mem++;
          3'b110: n_wb++;
          default: ;
        endcase
        n_req += int'(uc_out_mem_req);
        n_we  += int'(uc_out_mem_we);
        n_err += int'(uc_out_err);
        if (uc_out_pc_write) begin
          n_pcw++; o_sel = uc_out_pc_sel; o_ph = uc_out_FSM;
        end
      end else if (act) begin
        act = 1'b0;
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: got a result, expected none");
        end else begin
          e = q.pop_front();
          chk("class", {24'b0, o_cls}, e.cls);
          chk("rs", {27'b0, o_rs}, e.rs);
          chk("rt", {27'b0, o_rt}, e.rt);
          if (e.ck_rd) chk("rd", {27'b0, o_rd}, e.rd);
          chk("imm", o_imm, e.imm);
          chk("stable", {31'b0, stable}, 32'd1);
          chk("n_decode", n_dec, 1);
          chk("n_exec", n_ex, 1);
          if (e.ck_alu) begin
            chk("alu_op", {28'b0, o_aop}, e.aop);
            chk("alu_src", {31'b0, o_asrc}, e.asrc);
          end
          chk("n_mem", n_mem, e.n_mem);
          chk("n_mem_req", n_req, e.n_mem);
          chk("n_mem_we", n_we, e.n_we);
          chk("n_wb", n_wb, e.n_wb);
          chk("n_pc_write", n_pcw, 1);
          chk("pc_sel", {30'b0, o_sel}, e.pcsel);
          chk("pc_phase", {29'b0, o_ph}, e.pcph);
          chk("n_err", n_err, e.err);
          chk("fetch_req", {31'b0, uc_out_fetch_req}, 32'd1);
          chk("fetch_cls", {24'b0, uc_out_FSM2}, 32'd0);
          chk("fetch_rd", {27'b0, uc_out_rd}, 32'd0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_fsm", {29'b0, uc_out_FSM}, 32'd0);
    chk("rst_fetch", {31'b0, uc_out_fetch_req}, 32'd0);
    chk("rst_others", {31'b0, others}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rel_hold", {29'b0, uc_out_FSM}, 32'd0);
    @(negedge clk);
    chk("rel_fsm", {29'b0, uc_out_FSM}, 32'd1);
    chk("rel_fetch", {31'b0, uc_out_fetch_req}, 32'd1);
    chk("rel_others", {31'b0, others}, 32'd0);

    sb_on = 1'b1;
    issue(32'h01095020, 1'b0, 0);
    issue(32'h8FA80004, 1'b0, 2);
    issue(32'h11090003, 1'b1, 0);
    issue(32'h11090003, 1'b0, 0);
    issue(32'h15090003, 1'b0, 0);
    issue(32'h0C000010, 1'b0, 0);
    issue(32'hFC000000, 1'b0, 0);
    issue(32'hAFA80004, 1'b0, 16);
    issue(32'hAFA80004, 1'b0, 15);
    issue(32'h8FA80004, 1'b0, 0);
    issue(32'h3508F00F, 1'b0, 0);
    for (int i = 0; i < 60; i++)
      issue(rand_instr(), 1'($urandom_range(0, 1)), rand_delay());
    @(negedge clk);
    chk("sb_drain", q.size(), 32'd0);
    sb_on = 1'b0;

    instr = 32'hAFA80004;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_fsm", {29'b0, uc_out_FSM}, 32'd4);
    chk("mid_req", {31'b0, uc_out_mem_req}, 32'd1);
    chk("mid_we", {31'b0, uc_out_mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_fsm", {29'b0, uc_out_FSM}, 32'd0);
    chk("async_fetch", {31'b0, uc_out_fetch_req}, 32'd0);
    chk("async_others", {31'b0, others}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rerel_fsm", {29'b0, uc_out_FSM}, 32'd1);
    chk("rerel_others", {31'b0, others}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
